// File: rtl/keccak_sponge_ctrl_pkg.sv
// keccak_pkg: shared constants, FSM state and buffer-operation encodings
// for the byte-serial SHA3-512 sponge controller.
`default_nettype none

package keccak_pkg;
    localparam int RATE_BYTES  = 72;
    localparam int RATE_BITS   = 576;
    localparam int STATE_BITS  = 1600;

    localparam logic [7:0] PAD_LAST         = 8'h80;
    localparam logic [7:0] PAD_FIRST_SHA3   = 8'h06;
    localparam logic [7:0] PAD_FIRST_KECCAK = 8'h01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        PAD     = 3'd2,
        ABSORB  = 3'd3,
        WAIT    = 3'd4,
        SQUEEZE = 3'd5,
        CLEAR   = 3'd6
    } sponge_state_t;

    typedef enum logic [2:0] {
        BUF_NOP      = 3'd0,
        BUF_WRITE    = 3'd1,
        BUF_PAD      = 3'd2,
        BUF_PAD_ONLY = 3'd3,
        BUF_CLEAR    = 3'd4
    } buf_op_t;
endpackage

`default_nettype wire

// File: rtl/keccak_sponge_ctrl_block_buf.sv
// sponge_block_buf: 576-bit rate block register with byte write, in-place
// padding from a given byte position, pad-only load and clear.
`default_nettype none

module sponge_block_buf
    import keccak_pkg::*;
#(
    parameter logic [7:0] PAD_FIRST = PAD_FIRST_SHA3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  buf_op_t              op,
    input  logic [6:0]           idx,
    input  logic [7:0]           data,
    output logic [RATE_BITS-1:0] block
);
    logic [RATE_BITS-1:0] padded;

    // Padding starts at idx: first pad byte there, zeros after it, and the
    // top bit of the final byte always set (merges with PAD_FIRST at idx 71).
    for (genvar b = 0; b < RATE_BYTES; b++) begin : g_pad
        localparam logic [7:0] TAIL = (b == RATE_BYTES - 1) ? PAD_LAST : 8'h00;
        logic [7:0] cur;
        assign cur = block[RATE_BITS-1-8*b -: 8];
        assign padded[RATE_BITS-1-8*b -: 8] =
            ((7'(b) == idx) ? PAD_FIRST : (7'(b) > idx) ? 8'h00 : cur) | TAIL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            block <= '0;
        end else begin
            case (op)
                BUF_WRITE:    block[10'(RATE_BITS-1) - 10'({idx, 3'b000}) -: 8] <= data;
                BUF_PAD:      block <= padded;
                BUF_PAD_ONLY: block <= {PAD_FIRST, {(RATE_BITS-16){1'b0}}, PAD_LAST};
                BUF_CLEAR:    block <= '0;
                default:      ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: byte-serial SHA3 sponge sequencer around f_permutation.
// Optional SPONGE_EMPTY_MSG_EN adds in_empty for hashing the empty message.
`default_nettype none

module keccak_sponge_ctrl
    import keccak_pkg::*;
#(
    parameter int         DIGEST_BYTES = 64,
    parameter logic [7:0] PAD_FIRST    = 8'h06
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    input  logic                  in_last,
`ifdef SPONGE_EMPTY_MSG_EN
    input  logic                  in_empty,
`endif
    output logic                  in_ready,
    output logic [RATE_BITS-1:0]  perm_in,
    output logic                  perm_in_ready,
    input  logic                  perm_ack,
    input  logic [STATE_BITS-1:0] perm_state,
    input  logic                  perm_out_ready,
    output logic                  perm_clear,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready,
    output logic                  busy
);
    localparam logic [6:0] LAST_BYTE = 7'(RATE_BYTES - 1);
    localparam logic [6:0] LAST_SQ   = 7'(DIGEST_BYTES - 1);

    sponge_state_t state;
    logic [6:0]    cnt;
    logic [6:0]    sq_idx;
    logic [6:0]    sq_next;
    logic          final_blk;
    logic          pend_pad;
    logic          accept;
    logic          empty_req;
    buf_op_t       buf_op;

`ifdef SPONGE_EMPTY_MSG_EN
    assign empty_req = in_empty;
`else
    assign empty_req = 1'b0;
`endif

    assign accept  = in_valid & in_ready;
    assign sq_next = sq_idx + 7'd1;

    sponge_block_buf #(.PAD_FIRST(PAD_FIRST)) u_buf (
        .clk   (clk),
        .reset (reset),
        .op    (buf_op),
        .idx   (cnt),
        .data  (in_byte),
        .block (perm_in)
    );

    // cnt doubles as the write position and, in PAD, the first pad position.
    always_comb begin
        buf_op = BUF_NOP;
        case (state)
            IDLE:    if (empty_req) buf_op = BUF_PAD_ONLY;
                     else if (accept) buf_op = BUF_WRITE;
            FILL:    if (accept) buf_op = BUF_WRITE;
            PAD:     buf_op = BUF_PAD;
            ABSORB:  if (perm_ack) buf_op = BUF_CLEAR;
            WAIT:    if (perm_out_ready && !final_blk && pend_pad) buf_op = BUF_PAD_ONLY;
            default: buf_op = BUF_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            sq_idx        <= '0;
            final_blk     <= 1'b0;
            pend_pad      <= 1'b0;
            in_ready      <= 1'b0;
            perm_in_ready <= 1'b0;
            perm_clear    <= 1'b0;
            dout          <= '0;
            dout_valid    <= 1'b0;
            dout_last     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            perm_clear <= 1'b0;
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (empty_req) begin
                        final_blk     <= 1'b1;
                        perm_in_ready <= 1'b1;
                        in_ready      <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ABSORB;
                    end else if (accept) begin
                        cnt  <= 7'd1;
                        busy <= 1'b1;
                        if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        cnt <= cnt + 7'd1;
                        if (cnt == LAST_BYTE) begin
                            // A last byte that fills the block needs a pad-only block after it.
                            in_ready      <= 1'b0;
                            final_blk     <= 1'b0;
                            pend_pad      <= in_last;
                            perm_in_ready <= 1'b1;
                            state         <= ABSORB;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= PAD;
                        end
                    end
                end
                PAD: begin
                    final_blk     <= 1'b1;
                    perm_in_ready <= 1'b1;
                    state         <= ABSORB;
                end
                ABSORB: begin
                    if (perm_ack) begin
                        perm_in_ready <= 1'b0;
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (perm_out_ready) begin
                        if (final_blk) begin
                            sq_idx     <= '0;
                            dout       <= perm_state[STATE_BITS-1 -: 8];
                            dout_valid <= 1'b1;
                            dout_last  <= (DIGEST_BYTES == 1);
                            state      <= SQUEEZE;
                        end else if (pend_pad) begin
                            pend_pad      <= 1'b0;
                            final_blk     <= 1'b1;
                            perm_in_ready <= 1'b1;
                            state         <= ABSORB;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= FILL;
                        end
                    end
                end
                SQUEEZE: begin
                    if (dout_ready) begin
                        if (sq_idx == LAST_SQ) begin
                            dout       <= '0;
                            dout_valid <= 1'b0;
                            dout_last  <= 1'b0;
                            final_blk  <= 1'b0;
                            perm_clear <= 1'b1;
                            state      <= CLEAR;
                        end else begin
                            sq_idx    <= sq_next;
                            dout      <= perm_state[11'(STATE_BITS-1) - 11'({sq_next, 3'b000}) -: 8];
                            dout_last <= (sq_next == LAST_SQ);
                        end
                    end
                end
                CLEAR: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
